// File: rtl/rsa_result_demux_if.sv
// Serial result bus between the Montgomery datapath and the result demux.
// The master drives the serial stream and select; the slave drives the word registers and status.
interface rsa_result_demux_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             sel;
  logic             bit_in;
  logic             bit_valid;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic             busy;
  logic             done;

  modport master (
    output start, sel, bit_in, bit_valid,
    input  a_out, b_out, busy, done
  );

  modport slave (
    input  start, sel, bit_in, bit_valid,
    output a_out, b_out, busy, done
  );
endinterface

// File: rtl/rsa_result_demux.sv
// Bit-serial result deserializer: collects a WIDTH-bit word LSB-first and writes
// it into destination register A or B, chosen by the select latched at start.
module rsa_result_demux #(
  parameter int unsigned WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  rsa_result_demux_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WRITE
  } state_e;

  state_e           state_q;
  logic             sel_q;
  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0] shadow_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             busy_q;
  logic             done_q;

  always_comb begin
    shadow_d = {bus.bit_in, shadow_q[WIDTH-1:1]};
  end

  // The destination register is loaded on the edge that enters WRITE, so the new
  // word and the done pulse are both visible during the single WRITE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= 1'b0;
      shadow_q <= '0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            sel_q    <= bus.sel;
            shadow_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.bit_valid) begin
            shadow_q <= shadow_d;
            if (cnt_q == LAST) begin
              if (sel_q) b_q <= shadow_d;
              else       a_q <= shadow_d;
              done_q  <= 1'b1;
              state_q <= WRITE;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        WRITE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.a_out = a_q;
  assign bus.b_out = b_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule
